// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit producing the HI/LO pair, one result bit per clock.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are fixed up at completion.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic               is_div;
   logic               neg_lo;   // negate product (mul) or quotient (div)
   logic               neg_hi;   // negate remainder
   logic               dbz;
   logic [WIDTH-1:0]   opnd;     // multiplicand (mul) or divisor (div)
   logic [2*WIDTH-1:0] acc;      // {partial product, multiplier} or {remainder, quotient}

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic               fits;
   logic [WIDTH-1:0]   diff;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   logic [WIDTH-1:0]   hi_res, lo_res;

   // op[0]=0 selects the signed variants (MULT, DIV).
   assign a_neg = ~op[0] & operand_a[WIDTH-1];
   assign b_neg = ~op[0] & operand_b[WIDTH-1];
   assign abs_a = a_neg ? -operand_a : operand_a;
   assign abs_b = b_neg ? -operand_b : operand_b;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      fits    = shifted >= {1'b0, opnd};
      // When the divisor fits, the true difference is below opnd, so WIDTH bits suffice.
      diff    = shifted[WIDTH-1:0] - opnd;
      if (is_div)
         acc_next = {(fits ? diff : shifted[WIDTH-1:0]), acc[WIDTH-2:0], fits};
      else
         acc_next = {sum, acc[WIDTH-1:1]};
   end

   always_comb begin
      prod = neg_lo ? -acc_next : acc_next;
      quo  = acc_next[WIDTH-1:0];
      rem  = acc_next[2*WIDTH-1:WIDTH];
      if (is_div) begin
         lo_res = neg_lo ? -quo : quo;
         hi_res = neg_hi ? -rem : rem;
      end else begin
         lo_res = prod[WIDTH-1:0];
         hi_res = prod[2*WIDTH-1:WIDTH];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         count  <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         dbz    <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (hi_we) hi_out <= hi_in;
               if (lo_we) lo_out <= lo_in;
               if (start) begin
                  state  <= RUN;
                  count  <= CW'(WIDTH - 1);
                  is_div <= op[1];
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= op[1] & a_neg;
                  dbz    <= op[1] & (operand_b == '0);
                  opnd   <= op[1] ? abs_b : abs_a;
                  acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (count != '0) begin
                  count <= count - 1'b1;
               end else begin
                  state <= DONE;
                  // A zero divisor leaves HI/LO untouched; only the flag reports it.
                  if (!dbz) begin
                     hi_out <= hi_res;
                     lo_out <= lo_res;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy        = (state == RUN);
   assign done        = (state == DONE);
   assign div_by_zero = (state == DONE) & dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random operations
// compared against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  operand_a = '0;
   logic [W-1:0]  operand_b = '0;
   logic          hi_we = 1'b0;
   logic          lo_we = 1'b0;
   logic [W-1:0]  hi_in = '0;
   logic [W-1:0]  lo_in = '0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi_out, lo_out;

   int            n_cmp = 0;
   int            n_bad = 0;

   // Reference model state: architectural HI/LO and expected flag of the last op.
   logic [W-1:0]  m_hi = '0;
   logic [W-1:0]  m_lo = '0;
   logic          m_dbz = 1'b0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .hi_we(hi_we), .lo_we(lo_we), .hi_in(hi_in), .lo_in(lo_in),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint     sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      m_dbz = 1'b0;
      case (o)
         2'b00: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
         default: begin
            if (b == '0) m_dbz = 1'b1;
            else if (o == 2'b10) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            else begin m_lo = a / b; m_hi = a % b; end
         end
      endcase
   endtask

   // Drive a start for one cycle from a negedge and update the model.
   task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(negedge clock);
      start = 1'b0;
      ref_op(o, a, b);
   endtask

   // Count busy cycles (bounded), optionally inject an ignored start + MTHI at cycle inject.
   task automatic wait_done(input string tag, input int inject);
      int          n = 0;
      logic        hold_ok = 1'b1;
      logic [W-1:0] h0 = hi_out;
      logic [W-1:0] l0 = lo_out;
      while (busy === 1'b1 && n < 2*W + 4) begin
         if (done !== 1'b0 || hi_out !== h0 || lo_out !== l0) hold_ok = 1'b0;
         if (n == inject) begin
            start = 1'b1; op = 2'b01; operand_a = $urandom; operand_b = $urandom;
            hi_we = 1'b1; hi_in = 32'hDEADBEEF;
         end else begin
            start = 1'b0; hi_we = 1'b0;
         end
         n++;
         @(negedge clock);
      end
      start = 1'b0; hi_we = 1'b0;
      check({tag, " busy_cycles"}, 64'(n), 64'(W));
      check({tag, " hold"}, 64'(hold_ok), 64'(1));
      check({tag, " done"}, 64'(done), 64'(1));
      check({tag, " hi"}, 64'(hi_out), 64'(m_hi));
      check({tag, " lo"}, 64'(lo_out), 64'(m_lo));
      check({tag, " dbz"}, 64'(div_by_zero), 64'(m_dbz));
   endtask

   task automatic check_idle(input string tag);
      @(negedge clock);
      check({tag, " done_pulse"}, 64'(done), 64'(0));
      check({tag, " dbz_clear"}, 64'(div_by_zero), 64'(0));
      check({tag, " idle"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #2;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset dbz", 64'(div_by_zero), 64'(0));
      check("reset hi", 64'(hi_out), 64'(0));
      check("reset lo", 64'(lo_out), 64'(0));
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // MULTU of two all-ones operands.
      start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done("multu_max", -1);
      check("multu_max hi_const", 64'(hi_out), 64'hFFFFFFFE);
      check("multu_max lo_const", 64'(lo_out), 64'h00000001);
      check_idle("multu_max");

      // MULT -3 x 7, then DIV -7 / 2 back-to-back from the DONE cycle.
      start_op(2'b00, 32'hFFFFFFFD, 32'd7);
      wait_done("mult_neg", -1);
      check("mult_neg lo_const", 64'(lo_out), 64'hFFFFFFEB);
      start_op(2'b10, 32'hFFFFFFF9, 32'd2);
      wait_done("div_b2b", -1);
      check("div_b2b lo_const", 64'(lo_out), 64'hFFFFFFFD);
      check("div_b2b hi_const", 64'(hi_out), 64'hFFFFFFFF);
      check_idle("div_b2b");

      // MTHI/MTLO preload, then divide by zero leaves them unchanged.
      hi_we = 1'b1; hi_in = 32'h11111111; lo_we = 1'b1; lo_in = 32'h22222222;
      @(negedge clock);
      hi_we = 1'b0; lo_we = 1'b0;
      m_hi = 32'h11111111; m_lo = 32'h22222222;
      check("mthi", 64'(hi_out), 64'h11111111);
      check("mtlo", 64'(lo_out), 64'h22222222);
      start_op(2'b11, 32'd100, 32'd0);
      wait_done("divu_zero", -1);
      check("divu_zero hi_kept", 64'(hi_out), 64'h11111111);
      start_op(2'b11, 32'd100, 32'd7);
      wait_done("divu_100_7", -1);
      check("divu_100_7 lo_const", 64'(lo_out), 64'd14);
      check("divu_100_7 hi_const", 64'(hi_out), 64'd2);
      check_idle("divu_100_7");

      // Start and MTHI during RUN are ignored.
      start_op(2'b00, 32'h00012345, 32'hFFFF0001);
      wait_done("run_ignore", 4);
      check_idle("run_ignore");

      // MTHI together with a start in IDLE: write lands, divide by zero keeps it.
      hi_we = 1'b1; hi_in = 32'hCAFEF00D;
      start_op(2'b11, 32'd5, 32'd0);
      hi_we = 1'b0;
      m_hi = 32'hCAFEF00D;
      wait_done("we_with_start", -1);
      check_idle("we_with_start");

      // Asynchronous reset mid-operation.
      start_op(2'b01, 32'd6, 32'd7);
      repeat (9) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      check("async_rst busy", 64'(busy), 64'(0));
      check("async_rst done", 64'(done), 64'(0));
      check("async_rst hi", 64'(hi_out), 64'(0));
      check("async_rst lo", 64'(lo_out), 64'(0));
      m_hi = '0; m_lo = '0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      start_op(2'b01, 32'd6, 32'd7);
      wait_done("after_rst", -1);
      check("after_rst lo_const", 64'(lo_out), 64'd42);
      check_idle("after_rst");

      // Signed divide overflow wraps without a flag.
      start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div_ovf", -1);
      check("div_ovf lo_const", 64'(lo_out), 64'h80000000);
      check("div_ovf hi_const", 64'(hi_out), 64'h00000000);
      check_idle("div_ovf");

      // Random operations, some back-to-back, with occasional zero divisors.
      for (int i = 0; i < 24; i++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         start_op(ro, ra, rb);
         wait_done($sformatf("rand%0d op%0d", i, ro), -1);
         if (i[0]) check_idle($sformatf("rand%0d", i));
      end
      check_idle("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two register read operands and produces the architectural HI/LO pair for MULT/MULTU/DIV/DIVU. HI/LO are also writable directly by MTHI/MTLO and readable by MFHI/MFLO. It processes one result bit per clock and stalls the pipeline through a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request a new operation; sampled on the rising clock edge
op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  rt value (multiplier / divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
hi_in  input  WIDTH  MTHI data
lo_in  input  WIDTH  MTLO data
busy  output  1  operation in progress; the pipeline must stall
done  output  1  one-cycle pulse; HI/LO hold the new result
div_by_zero  output  1  valid while done=1; set for DIV/DIVU with operand_b=0
hi_out  output  WIDTH  HI register
lo_out  output  WIDTH  LO register

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0, at any time including mid-operation): state=IDLE, busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0. The iteration counter and all working registers are cleared. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE to RUN: start=1 at the edge. That edge latches op and operands, takes magnitudes for signed ops and records the result signs, and loads counter=WIDTH-1.
  - DONE to IDLE: start=0.
  - RUN to RUN: counter>0; the counter decrements each edge.
  - RUN to DONE: counter=0.
- Latency: start accepted at edge E. busy=1 after edges E..E+WIDTH-1, i.e. for exactly WIDTH cycles. At edge E+WIDTH, hi_out/lo_out are updated, done=1 and busy=0. done holds for one cycle only.
- Back-to-back: start is accepted while in DONE, so the next operation begins with no bubble.
- start while in RUN is ignored; it is neither queued nor does it affect the current operation.
- Multiply: shift-add over magnitudes into a 2*WIDTH product.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
  - MULT negates the 2*WIDTH product when the operand signs differ.
- Divide: restoring algorithm over magnitudes. LO = quotient, HI = remainder.
  - DIV: quotient is negative when the operand signs differ; the remainder takes the sign of the dividend (truncating division).
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0. This is natural wrap; no flag is raised.
- Divide by zero (DIV/DIVU with operand_b=0):
  - Same WIDTH-cycle latency as a normal divide.
  - At completion hi_out/lo_out are left unchanged, div_by_zero=1 together with done.
  - div_by_zero is 0 in every other cycle and for all multiplies.
- MTHI/MTLO:
  - In IDLE or DONE, hi_we/lo_we write hi_in/lo_in at the edge; the new value is visible the next cycle.
  - In RUN, the write enables are ignored.
  - If hi_we and start occur in the same IDLE cycle, the write takes effect and the operation is also accepted. The operation's result later overwrites HI/LO.
- hi_out/lo_out are driven straight from the registers. They keep their old values for the entire RUN period and change only at the DONE transition.

Test Plan:
- MULTU with 0xFFFFFFFF, 0xFFFFFFFF, start for 1 cycle -> busy=1 for 32 cycles; then done=1 for 1 cycle with HI=0xFFFFFFFE, LO=0x00000001, div_by_zero=0.
- MULT -3 (0xFFFFFFFD) × 7, then a back-to-back start (start held at DONE) for DIV -7 / 2 -> first result HI=0xFFFFFFFF, LO=0xFFFFFFEB. Second result, exactly 32 cycles later, is LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Preload HI=0x11111111, LO=0x22222222 via MTHI/MTLO, then DIVU 100 / 0 -> after 32 cycles done=1, div_by_zero=1, HI/LO unchanged. DIVU 100 / 7 then gives LO=14, HI=2.
- During RUN at cycle 5: start with new operands, plus hi_we=1 with hi_in=0xDEADBEEF -> both ignored. The result matches the original operands and completes at the original time.
- Start MULTU 6×7, drive reset=0 asynchronously at cycle 10 (mid-clock) -> busy, done, HI, LO go to 0 immediately. After reset=1, a new MULTU 6×7 completes 32 cycles after its start with LO=42, HI=0.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_by_zero=0.
